// File: rtl/hps_reset_pulse_gen.sv
// hps_reset_pulse_gen: multi-channel edge-to-pulse generator for HPS reset requests.
// Ports: clk, reset (sync, active-high), signal_in[NUM_CH] async request levels,
//   clr_dropped (1-cycle clear), pulse_out[NUM_CH] active-high pulses,
//   busy (pulse or holdoff running), active_ch (owning channel, 0 when idle),
//   dropped[NUM_CH] sticky flags for discarded edges.
module hps_reset_pulse_gen #(
  parameter int NUM_CH = 3,
  parameter int CNT_W = 8,
  parameter logic [NUM_CH*CNT_W-1:0] PULSE_EXT = {8'd32, 8'd2, 8'd6},
  parameter logic [2*NUM_CH-1:0] EDGE_TYPE = {2'b01, 2'b01, 2'b01},
  parameter logic [NUM_CH-1:0] IGNORE_BUSY = 3'b111,
  parameter bit EXCLUSIVE = 1'b1,
  parameter int HOLDOFF = 4,
  localparam int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] signal_in,
  input  logic              clr_dropped,
  output logic [NUM_CH-1:0] pulse_out,
  output logic              busy,
  output logic [AW-1:0]     active_ch,
  output logic [NUM_CH-1:0] dropped
);

  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLDOFF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [NUM_CH-1:0] sync1, sync2, prev;
  logic [1:0]        mask_cnt;
  logic              armed;
  logic [NUM_CH-1:0] edge_det;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [AW-1:0]     act, act_nx, win;
  logic [HW-1:0]     hcnt, hcnt_nx;
  logic [NUM_CH-1:0] win_oh, act_oh;
  logic [NUM_CH-1:0] load, kill, drop_set;
  logic [CNT_W-1:0]  cnt_act;
  logic              act_hit, act_rt;

  function automatic logic [CNT_W-1:0] plen(input int i);
    logic [CNT_W-1:0] v;
    v = PULSE_EXT[i*CNT_W +: CNT_W];
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  // Mask stays active for the first three cycles after reset so a
  // level held high through reset cannot look like a fresh edge.
  assign armed = (mask_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      mask_cnt <= '0;
    end else begin
      sync1 <= signal_in;
      sync2 <= sync1;
      prev  <= sync2;
      if (!armed) mask_cnt <= mask_cnt + 2'd1;
    end
  end

  always_comb begin
    edge_det = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (EDGE_TYPE[2*i +: 2])
        2'b00:   edge_det[i] = prev[i] & ~sync2[i];
        2'b01:   edge_det[i] = ~prev[i] & sync2[i];
        2'b10:   edge_det[i] = prev[i] ^ sync2[i];
        default: edge_det[i] = 1'b0;
      endcase
    end
    if (!armed) edge_det = '0;
  end

  // Lowest set bit wins: isolate it and derive its index.
  always_comb begin
    win_oh  = edge_det & (~edge_det + NUM_CH'(1));
    win     = '0;
    act_oh  = '0;
    cnt_act = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (win_oh[i]) win = AW'(i);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      act_oh[i] = (act == AW'(i));
      if (act_oh[i]) cnt_act = cnt[i];
    end
    act_hit = |(edge_det & act_oh);
    act_rt  = |(~IGNORE_BUSY & act_oh);
  end

  // Next-state / arbitration.
  always_comb begin
    state_nx = state;
    act_nx   = act;
    hcnt_nx  = hcnt;
    load     = '0;
    kill     = '0;
    drop_set = '0;
    if (!EXCLUSIVE) begin
      state_nx = IDLE;
      act_nx   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        load[i] = edge_det[i] &
                  ((cnt[i] == '0) | ~IGNORE_BUSY[i]);
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (|edge_det) begin
            load     = win_oh;
            drop_set = edge_det & ~win_oh;
            act_nx   = win;
            state_nx = PULSE;
          end
        end
        PULSE: begin
          if ((|edge_det) && (win < act)) begin
            // Preempted owner is cut short, not flagged as dropped.
            load     = win_oh;
            kill     = act_oh;
            drop_set = edge_det & ~win_oh & ~act_oh;
            act_nx   = win;
          end else begin
            drop_set = edge_det & ~act_oh;
            if (act_hit && act_rt) load = act_oh;
            if (!(act_hit && act_rt) && cnt_act == CNT_W'(1)) begin
              act_nx = '0;
              if (HOLDOFF > 0) begin
                state_nx = HOLD;
                hcnt_nx  = HOLD_LD;
              end else begin
                state_nx = IDLE;
              end
            end
          end
        end
        HOLD: begin
          drop_set = edge_det;
          hcnt_nx  = hcnt - HW'(1);
          if (hcnt == HW'(1)) state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
          act_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      act     <= '0;
      hcnt    <= '0;
      dropped <= '0;
    end else begin
      state   <= state_nx;
      act     <= act_nx;
      hcnt    <= hcnt_nx;
      dropped <= (dropped & ~{NUM_CH{clr_dropped}}) | drop_set;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) cnt[i] <= '0;
      else if (load[i]) cnt[i] <= plen(i);
      else if (kill[i]) cnt[i] <= '0;
      else if (cnt[i] != '0) cnt[i] <= cnt[i] - CNT_W'(1);
    end
  end

  // Outputs.
  always_comb begin
    pulse_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pulse_out[i] = (cnt[i] != '0);
    end
  end

  assign busy = EXCLUSIVE ? (state != IDLE) : (|pulse_out);
  assign active_ch = EXCLUSIVE ? act : '0;

endmodule

// File: tb/tb_hps_reset_pulse_gen.sv
// tb_hps_reset_pulse_gen: bench for hps_reset_pulse_gen.
// Three configurations driven in parallel, each against a reference model.
module tb_hps_reset_pulse_gen;

  logic clk = 1'b0;
  logic rst, clr;
  logic [2:0] sig;

  logic [2:0] po [3];
  logic       bz [3];
  logic [1:0] ac [3];
  logic [2:0] dr [3];

  int n_err = 0;
  int n_chk = 0;

  int         len  [3][3];
  logic [1:0] et   [3][3];
  logic [2:0] ib   [3];
  bit         excl [3];
  int         hoff [3];

  int         rem   [3][3];
  int         owner [3];
  int         hold  [3];
  logic [2:0] drp   [3];
  logic [2:0] hist  [3];
  int         since;

  int wcnt [3][3];
  int bcnt [3];

  always #5 clk = ~clk;

  hps_reset_pulse_gen u0 (
    .clk(clk), .reset(rst), .signal_in(sig),
    .clr_dropped(clr), .pulse_out(po[0]), .busy(bz[0]),
    .active_ch(ac[0]), .dropped(dr[0])
  );

  hps_reset_pulse_gen #(
    .PULSE_EXT({8'd5, 8'd3, 8'd6}),
    .EDGE_TYPE({2'b10, 2'b00, 2'b01}),
    .IGNORE_BUSY(3'b110),
    .HOLDOFF(0)
  ) u1 (
    .clk(clk), .reset(rst), .signal_in(sig),
    .clr_dropped(clr), .pulse_out(po[1]), .busy(bz[1]),
    .active_ch(ac[1]), .dropped(dr[1])
  );

  hps_reset_pulse_gen #(
    .PULSE_EXT({8'd0, 8'd3, 8'd4}),
    .EDGE_TYPE({2'b10, 2'b11, 2'b00}),
    .IGNORE_BUSY(3'b010),
    .EXCLUSIVE(1'b0),
    .HOLDOFF(2)
  ) u2 (
    .clk(clk), .reset(rst), .signal_in(sig),
    .clr_dropped(clr), .pulse_out(po[2]), .busy(bz[2]),
    .active_ch(ac[2]), .dropped(dr[2])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int u, input int i);
    return (len[u][i] == 0) ? 1 : len[u][i];
  endfunction

  function automatic int lowest(input logic [2:0] e);
    int r = 3;
    for (int i = 2; i >= 0; i--) if (e[i]) r = i;
    return r;
  endfunction

  function automatic logic [2:0] edges(input int u, input logic [2:0] c,
                                       input logic [2:0] p);
    logic [2:0] e = '0;
    for (int i = 0; i < 3; i++) begin
      case (et[u][i])
        2'b00:   e[i] = p[i] & ~c[i];
        2'b01:   e[i] = ~p[i] & c[i];
        2'b10:   e[i] = p[i] ^ c[i];
        default: e[i] = 1'b0;
      endcase
    end
    return e;
  endfunction

  // hist[0..2] hold the input samples of the last three clock edges;
  // a decision at this edge sees the samples from two and three edges ago.
  task automatic model_step();
    logic [2:0] c, p, e, drop;
    bit armed;
    int w, o;
    if (rst) begin
      for (int u = 0; u < 3; u++) begin
        for (int i = 0; i < 3; i++) rem[u][i] = 0;
        owner[u] = 0;
        hold[u]  = 0;
        drp[u]   = '0;
      end
      for (int k = 0; k < 3; k++) hist[k] = '0;
      since = 0;
      return;
    end
    c = hist[1];
    p = hist[2];
    armed = (since >= 3);
    if (since < 3) since++;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = sig;
    for (int u = 0; u < 3; u++) begin
      e = armed ? edges(u, c, p) : 3'b000;
      drop = '0;
      if (!excl[u]) begin
        for (int i = 0; i < 3; i++) begin
          if (e[i] && (rem[u][i] == 0 || !ib[u][i])) rem[u][i] = eff(u, i);
          else if (rem[u][i] > 0) rem[u][i]--;
        end
      end else if (hold[u] > 0) begin
        drop = e;
        hold[u]--;
      end else if (rem[u][owner[u]] == 0) begin
        if (e != 0) begin
          w = lowest(e);
          rem[u][w] = eff(u, w);
          owner[u] = w;
          drop = e & ~(3'b001 << w);
        end
      end else begin
        o = owner[u];
        if (e != 0 && lowest(e) < o) begin
          w = lowest(e);
          rem[u][o] = 0;
          rem[u][w] = eff(u, w);
          drop = e & ~(3'b001 << w) & ~(3'b001 << o);
          owner[u] = w;
        end else begin
          drop = e & ~(3'b001 << o);
          if (e[o] && !ib[u][o]) begin
            rem[u][o] = eff(u, o);
          end else begin
            rem[u][o]--;
            if (rem[u][o] == 0) begin
              hold[u]  = hoff[u];
              owner[u] = 0;
            end
          end
        end
      end
      drp[u] = (clr ? 3'b000 : drp[u]) | drop;
    end
  endtask

  task automatic cyc();
    logic [2:0] ep;
    logic eb;
    logic [1:0] ea;
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      ep = '0;
      for (int i = 0; i < 3; i++) ep[i] = (rem[u][i] > 0);
      eb = excl[u] ? ((|ep) || hold[u] > 0) : (|ep);
      ea = (excl[u] && (|ep)) ? 2'(owner[u]) : 2'd0;
      chk($sformatf("u%0d_pulse", u), 32'(po[u]), 32'(ep));
      chk($sformatf("u%0d_busy", u), 32'(bz[u]), 32'(eb));
      chk($sformatf("u%0d_act", u), 32'(ac[u]), 32'(ea));
      chk($sformatf("u%0d_drop", u), 32'(dr[u]), 32'(drp[u]));
      for (int i = 0; i < 3; i++) if (po[u][i] === 1'b1) wcnt[u][i]++;
      if (bz[u] === 1'b1) bcnt[u]++;
    end
  endtask

  task automatic cycn(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic clear_cnt();
    for (int u = 0; u < 3; u++) begin
      bcnt[u] = 0;
      for (int i = 0; i < 3; i++) wcnt[u][i] = 0;
    end
  endtask

  initial begin
    int n;
    len[0] = '{6, 2, 32};
    et[0]  = '{2'b01, 2'b01, 2'b01};
    ib[0]  = 3'b111; excl[0] = 1'b1; hoff[0] = 4;
    len[1] = '{6, 3, 5};
    et[1]  = '{2'b01, 2'b00, 2'b10};
    ib[1]  = 3'b110; excl[1] = 1'b1; hoff[1] = 0;
    len[2] = '{4, 3, 0};
    et[2]  = '{2'b00, 2'b11, 2'b10};
    ib[2]  = 3'b010; excl[2] = 1'b0; hoff[2] = 2;
    for (int k = 0; k < 3; k++) hist[k] = '0;
    since = 0;
    clear_cnt();

    sig = '0; clr = 1'b0; rst = 1'b1;
    cycn(2);
    chk("rst_pulse", 32'(po[0]), 0);
    chk("rst_busy", 32'(bz[0]), 0);
    chk("rst_act", 32'(ac[0]), 0);
    chk("rst_drop", 32'(dr[0]), 0);
    rst = 1'b0;
    cycn(3);

    // Edge detect, latency and width.
    clear_cnt();
    sig[0] = 1'b1;
    cycn(2);
    chk("t1_lat2", 32'(po[0][0]), 0);
    cyc();
    chk("t1_lat3", 32'(po[0][0]), 1);
    cycn(13);
    chk("t1_width", wcnt[0][0], 6);
    chk("t1_busy", bcnt[0], 10);

    // Simultaneous requests: lower index wins.
    clear_cnt();
    sig = 3'b110;
    cycn(12);
    chk("t2_w1", wcnt[0][1], 2);
    chk("t2_w2", wcnt[0][2], 0);
    chk("t2_drop", 32'(dr[0]), 3'b100);

    // Preemption of a long pulse.
    clr = 1'b1; cyc(); clr = 1'b0;
    sig = 3'b000;
    cycn(10);
    chk("t3_pre", 32'(dr[0]), 0);
    clear_cnt();
    sig[2] = 1'b1;
    cycn(12);
    sig[0] = 1'b1;
    cycn(2);
    chk("t3_before", 32'(po[0]), 3'b100);
    cyc();
    chk("t3_swap", 32'(po[0]), 3'b001);
    cycn(12);
    chk("t3_w2", wcnt[0][2], 12);
    chk("t3_w0", wcnt[0][0], 6);
    chk("t3_drop", 32'(dr[0]), 0);

    // Holdoff drop, then clear colliding with a new drop.
    sig[0] = 1'b0;
    cycn(12);
    sig[0] = 1'b1;
    n = 0;
    while (po[0][0] !== 1'b1 && n < 10) begin cyc(); n++; end
    chk("t4_rise", 32'(po[0][0]), 1);
    n = 0;
    while (po[0][0] !== 1'b0 && n < 20) begin cyc(); n++; end
    chk("t4_fall", 32'(po[0][0]), 0);
    clear_cnt();
    sig[1] = 1'b1;
    cycn(8);
    chk("t4_w1", wcnt[0][1], 0);
    chk("t4_drop", 32'(dr[0]), 3'b010);
    sig[2] = 1'b0; sig[0] = 1'b0;
    cycn(12);
    sig[0] = 1'b1;
    cycn(3);
    sig[2] = 1'b1;
    cycn(2);
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("t4_clrset", 32'(dr[0]), 3'b100);

    // Retrigger on u1, ignore on u0.
    sig = 3'b000;
    cycn(14);
    clear_cnt();
    sig[0] = 1'b1; cycn(2);
    sig[0] = 1'b0; cyc();
    sig[0] = 1'b1; cycn(16);
    chk("t5_retrig", wcnt[1][0], 9);
    chk("t5_ignore", wcnt[0][0], 6);

    // Level held through reset, then reset mid-pulse.
    rst = 1'b1; cycn(2);
    chk("t6_rst_pulse", 32'(po[0]), 0);
    chk("t6_rst_busy", 32'(bz[0]), 0);
    rst = 1'b0;
    clear_cnt();
    cycn(15);
    chk("t6_held0", wcnt[0][0], 0);
    chk("t6_held1", wcnt[1][0], 0);
    sig[0] = 1'b0; cycn(3);
    sig[0] = 1'b1; cycn(6);
    chk("t6_mid_on", 32'(po[0][0]), 1);
    rst = 1'b1; cyc();
    chk("t6_mid_pulse", 32'(po[0]), 0);
    chk("t6_mid_busy", 32'(bz[0]), 0);
    chk("t6_mid_drop", 32'(dr[0]), 0);
    rst = 1'b0;
    cycn(5);

    // Random traffic.
    for (int k = 0; k < 4000; k++) begin
      int b;
      rst = ($urandom_range(0, 399) == 0);
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        b = $urandom_range(0, 2);
        sig[b] = ~sig[b];
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
